led_display_arbiter: RTL and testbench
======================================

# led_display_arbiter

Shares the board's 8-bit LED bank between up to `NUM_REQ` pattern sources (KITT sweep, self-test status, error codes, user patterns) using round-robin arbitration with a guaranteed minimum ownership time. When no source requests the LEDs, a default pattern is shown. The block sits between the pattern generators and the LED pins and is the only driver of `led_display_o`. It applies `LED_POLARITY` once, so every source supplies active-high patterns.

## Interface
- `CLK_IN_MHZ`, 125: input clock frequency in MHz.
- `LED_POLARITY`, 1'b0: 1 = LED lit by a high output; 0 = LED lit by a low output.
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `HOLD_MS`, 250: minimum ownership time in ms before the block may rotate to another requester.

- `clk_i`, input, 1: single system clock.
- `rstn_i`, input, 1: reset, asynchronous, active-low.
- `req_i`, input, NUM_REQ: per-source request; level-sensitive, held for as long as the source wants the LEDs.
- `pattern_i`, input, NUM_REQ×8: per-source active-high pattern; sampled every cycle while that source is granted.
- `default_i`, input, 8: active-high pattern shown when nothing is granted.
- `gnt_o`, output, NUM_REQ: one-hot or zero grant; registered.
- `led_display_o`, output, 8: polarity-applied LED drive; registered.

## Operation
- `HoldCycles` = CLK_IN_MHZ·1000·HOLD_MS. The hold counter width is $clog2(HoldCycles+1).
- Under `SIM`, `HoldCycles` = 4.
- States are IDLE and OWNED.
- **IDLE**
  - `gnt_o` = 0 and the display shows `default_i`.
  - If any `req_i` is set, pick a winner round-robin starting at pointer `rr_ptr`, go to OWNED, and load the hold counter with `HoldCycles`-1.
- **OWNED** (owner k)
  - The display shows `pattern_i[k]`. The hold counter decrements to 0 and saturates there.
  - If `req_i[k]` drops, release immediately, regardless of the hold counter:
    - if another request is pending, grant the next round-robin winner and reload the counter;
    - otherwise go to IDLE.
  - If `req_i[k]` is still high, the counter is 0, and another request is pending, rotate to the next round-robin winner and reload the counter.
  - If `req_i[k]` is still high and either the counter is nonzero or no other request is pending, stay with k.
- **Round-robin**
  - After granting k, set `rr_ptr` = (k+1) mod NUM_REQ.
  - The search scans `rr_ptr`, `rr_ptr`+1, … with wrap-around.
  - The current owner is excluded from the scan when rotating.
- **Polarity:** `led_display_o` = LED_POLARITY ? pat : ~pat.
- **Simultaneous events:** owner release and new requests in the same cycle are handled as a single decision. There is never a cycle with `gnt_o` = 0 between owners.
- **Reset mid-operation:** all state clears asynchronously and the next cycle starts in IDLE.

## Timing
- Reset values:
  - state = IDLE;
  - `gnt_o` = 0;
  - `rr_ptr` = 0;
  - hold counter = 0;
  - `led_display_o` = all-off, i.e. 8'h00 if LED_POLARITY=1, else 8'hFF.
- **Grant latency:** request at cycle n gives `gnt_o` at edge n+1.
- **Display latency:** `led_display_o` reflects the owner (or default) selected by the `gnt_o` value of the previous cycle. The display therefore lags `gnt_o` by exactly one cycle, and a pattern change on `pattern_i[k]` while k is granted appears one cycle later.
- **Release:** `req_i[k]` low at cycle n means `gnt_o[k]` is low from edge n+1.
- **Rotation:** occurs no earlier than `HoldCycles` cycles after the grant edge.
- **Requester protocol:** sources must tolerate `gnt_o` being withdrawn while `req_i` is still high, which happens on rotation. A source that still has `req_i` high simply waits its turn again.

## Structure
- Package `led_pkg`:
  - state enum `led_arb_state_t` {IDLE, OWNED};
  - function `led_drive(pat, polarity)`;
  - constant `LedAllOff`.
- Sub-module `led_rr_arbiter`:
  - holds `rr_ptr`;
  - input: req mask with the owner optionally masked, plus an `advance` strobe;
  - outputs: one-hot winner and valid.
- The top level holds the FSM, the hold counter, the grant register and the output mux/register.

## Test plan
- **Reset values:** assert `rstn_i` mid-stream with LED_POLARITY=0 → `gnt_o`=0 and `led_display_o`=8'hFF immediately; after release, with no requests and `default_i`=8'h81, the output is 8'h7E on the next cycle.
- **Single requester:** `req_i`=4'b0100, `pattern_i[2]`=8'h3C → `gnt_o`=4'b0100 at n+1, `led_display_o`=~8'h3C at n+2; the grant holds indefinitely.
- **Hold then rotate:** SIM build, `req_i`=4'b0011 from cycle 0 → grant 0 for 4 cycles, then grant 1 for 4 cycles, then back to 0; `gnt_o` never goes to 0.
- **Early release:** owner 1 drops `req_i` after 1 cycle while `req_i[3]` is pending → `gnt_o`=4'b1000 on the next edge, with no wait for the hold counter.
- **Wrap-around fairness:** `rr_ptr`=3, `req_i`=4'b1001 → grant 3, then 0; all four requesting → grants follow 0,1,2,3,0.
- **Simultaneous events:** owner releases and all others request in the same cycle → exactly one new one-hot grant, chosen by `rr_ptr`; `led_display_o` switches to that source's pattern one cycle later.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED display arbiter.
package led_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } led_arb_state_t;

    // Active-high pattern with every LED dark.
    localparam logic [7:0] LedAllOff = 8'h00;

    // Simulation builds use a short hold time so rotation can be observed quickly.
`ifdef SIM
    localparam int SimHoldDefault = 4;
`else
    localparam int SimHoldDefault = 0;
`endif

    // Convert an active-high pattern into the pin drive level for the board.
    function automatic logic [7:0] led_drive(input logic [7:0] pat, input logic polarity);
        return polarity ? pat : ~pat;
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Round-robin winner search with a pointer that advances past each granted source.
module led_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);
    localparam int PtrW = $clog2(NUM_REQ);

    logic [PtrW-1:0] rr_ptr;
    logic [PtrW-1:0] win_idx;
    logic [PtrW-1:0] idx;

    // Scan from rr_ptr with wrap-around and take the first active request.
    always_comb begin
        winner  = '0;
        valid   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PtrW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

    // Move the pointer just past the source that was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Shares the 8-bit LED bank between pattern sources with round-robin
// arbitration and a minimum ownership time; shows a default pattern when idle.
module led_display_arbiter
    import led_pkg::*;
#(
    parameter int   CLK_IN_MHZ      = 125,
    parameter logic LED_POLARITY    = 1'b0,
    parameter int   NUM_REQ         = 4,
    parameter int   HOLD_MS         = 250,
    parameter int   SIM_HOLD_CYCLES = SimHoldDefault
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0][7:0] pattern_i,
    input  logic [7:0]              default_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [7:0]              led_display_o
);
    // A nonzero SIM_HOLD_CYCLES replaces the real-time hold for short simulations.
    localparam int HoldCycles = (SIM_HOLD_CYCLES > 0) ? SIM_HOLD_CYCLES
                                                      : CLK_IN_MHZ * 1000 * HOLD_MS;
    localparam int CntW = $clog2(HoldCycles + 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);

    led_arb_state_t     state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_winner;
    logic               arb_valid;
    logic               advance;
    logic [CntW-1:0]    cnt, cnt_nxt;
    logic               owner_req;
    logic [7:0]         sel_pat;

    assign owner_req = |(req_i & gnt_o);

    led_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .req     (arb_req),
        .advance (advance),
        .winner  (arb_winner),
        .valid   (arb_valid)
    );

    // Next-state decision: release, rotation and new grants resolved in one step.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        advance   = 1'b0;
        arb_req   = req_i;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (arb_valid) begin
                    state_nxt = OWNED;
                    gnt_nxt   = arb_winner;
                    cnt_nxt   = HoldLoad;
                    advance   = 1'b1;
                end
            end
            OWNED: begin
                // The owner never competes against itself when handing over.
                arb_req = req_i & ~gnt_o;
                if (!owner_req || cnt == '0) begin
                    if (arb_valid) begin
                        gnt_nxt = arb_winner;
                        cnt_nxt = HoldLoad;
                        advance = 1'b1;
                    end else if (!owner_req) begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered FSM state, grant and hold counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            gnt_o <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt_o <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Select the granted source's pattern (grant is one-hot) or the default.
    always_comb begin
        sel_pat = default_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) sel_pat = pattern_i[i];
        end
    end

    // Output register: display follows the registered grant by one cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            led_display_o <= led_drive(LedAllOff, LED_POLARITY);
        end else begin
            led_display_o <= led_drive(sel_pat, LED_POLARITY);
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter (active-low LEDs, 4 sources, hold of 4 cycles).
module tb_led_display_arbiter;

    logic            clk  = 1'b0;
    logic            rstn = 1'b1;
    logic [3:0]      req  = 4'b0000;
    logic [3:0][7:0] pat;
    logic [7:0]      dflt;
    logic [3:0]      gnt;
    logic [7:0]      led;

    int n_checks = 0;
    int n_fail   = 0;

    led_display_arbiter #(
        .CLK_IN_MHZ      (125),
        .LED_POLARITY    (1'b0),
        .NUM_REQ         (4),
        .HOLD_MS         (250),
        .SIM_HOLD_CYCLES (4)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_i         (req),
        .pattern_i     (pat),
        .default_i     (dflt),
        .gnt_o         (gnt),
        .led_display_o (led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, checking the grant after every edge.
    task automatic gnt_for(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {4'h0, gnt}, {4'h0, exp});
        end
    endtask

    initial begin
        pat[0] = 8'h11;
        pat[1] = 8'h22;
        pat[2] = 8'h3C;
        pat[3] = 8'h48;
        dflt   = 8'h81;

        // Reset state
        #2 rstn = 1'b0;
        step();
        step();
        chk("reset_gnt", {4'h0, gnt}, 8'h00);
        chk("reset_led", led, 8'hFF);
        rstn = 1'b1;
        step();
        chk("idle_gnt", {4'h0, gnt}, 8'h00);
        chk("idle_led_default", led, 8'h7E);

        // Hold then rotate between sources 0 and 1
        req = 4'b0011;
        gnt_for("rot_g0_first", 4'b0001, 1);
        step();
        chk("rot_g0_hold", {4'h0, gnt}, 8'h01);
        chk("rot_led_p0", led, 8'hEE);
        gnt_for("rot_g0_hold", 4'b0001, 2);
        gnt_for("rot_to_g1", 4'b0010, 1);
        step();
        chk("rot_g1_hold", {4'h0, gnt}, 8'h02);
        chk("rot_led_p1", led, 8'hDD);
        gnt_for("rot_g1_hold", 4'b0010, 2);
        gnt_for("rot_back_g0", 4'b0001, 1);
        req = 4'b0000;
        gnt_for("release_idle", 4'b0000, 1);
        step();
        chk("idle_led_again", led, 8'h7E);

        // Single requester holds indefinitely
        req = 4'b0100;
        step();
        chk("single_gnt", {4'h0, gnt}, 8'h04);
        chk("single_led_lag", led, 8'h7E);
        step();
        chk("single_led", led, 8'hC3);
        gnt_for("single_hold", 4'b0100, 10);
        pat[2] = 8'hF0;
        step();
        chk("single_pat_change", led, 8'h0F);
        req = 4'b0000;
        gnt_for("single_release", 4'b0000, 1);

        // Wrap-around: pointer at 3, sources 3 and 0 requesting
        req = 4'b1001;
        gnt_for("wrap_g3", 4'b1000, 1);
        gnt_for("wrap_g3_hold", 4'b1000, 3);
        gnt_for("wrap_g0", 4'b0001, 1);

        // Owner 0 drops while 1 and 3 request: pointer at 1 picks source 1
        req = 4'b1010;
        step();
        chk("handover_g1", {4'h0, gnt}, 8'h02);
        chk("handover_led_p0", led, 8'hEE);
        step();
        chk("handover_g1_hold", {4'h0, gnt}, 8'h02);
        chk("handover_led_p1", led, 8'hDD);

        // Early release: owner 1 drops, source 3 granted without waiting
        req = 4'b1000;
        gnt_for("early_g3", 4'b1000, 1);

        // Simultaneous: owner 3 drops as 0,1,2 request; pointer at 0
        req = 4'b0111;
        step();
        chk("simul_g0", {4'h0, gnt}, 8'h01);
        chk("simul_led_p3", led, 8'hB7);
        step();
        chk("simul_led_p0", led, 8'hEE);

        // All four requesting: 0 (remaining hold), then 1,2,3,0
        req = 4'b1111;
        gnt_for("all_g0_hold", 4'b0001, 2);
        gnt_for("all_g1", 4'b0010, 1);
        gnt_for("all_g1_hold", 4'b0010, 3);
        gnt_for("all_g2", 4'b0100, 1);
        gnt_for("all_g2_hold", 4'b0100, 3);
        gnt_for("all_g3", 4'b1000, 1);
        gnt_for("all_g3_hold", 4'b1000, 3);
        gnt_for("all_g0", 4'b0001, 1);

        // Reset mid-operation clears immediately; pointer restarts at 0
        #2 rstn = 1'b0;
        #1;
        chk("midreset_gnt", {4'h0, gnt}, 8'h00);
        chk("midreset_led", led, 8'hFF);
        step();
        rstn = 1'b1;
        step();
        chk("postreset_g0", {4'h0, gnt}, 8'h01);
        chk("postreset_led_default", led, 8'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
